// File: rtl/iobus_sequencer.sv
// ---------------------------------------------------------------------------
// iobus_sequencer
//   Slow I/O bus cycle sequencer. It sits in front of the FSB DTACK/VPA logic
//   and converts CPU I/O accesses into request/acknowledge transactions with
//   the slow-bus controller. Eligible writes can be posted, which releases the
//   CPU before the slow-bus cycle has finished.
//
// Parameters
//   POST_EN   1 = IOPWCS writes are posted, 0 = every access is non-posted
//   REQ_MIN   minimum FCLK cycles IOREQ stays high (1..15)
//   WDT_MAX   FCLK cycles allowed in ACTIVE before forced completion
//
// Ports
//   FCLK       in   system clock, rising edge
//   nRST       in   asynchronous active-low reset
//   BACT       in   bus active from FSB
//   IOCS       in   access targets the slow I/O bus
//   IOPWCS     in   access is eligible for write posting
//   nWE        in   CPU R/W, 0 = write
//   IOACT      in   slow-bus controller has taken the request
//   IODONE     in   one-cycle pulse, slow-bus cycle finished
//   IOREQ      out  request to slow-bus controller
//   ALE        out  one-cycle pulse, latch CPU address/data into I/O buffer
//   IOPWReady  out  posted write captured, CPU may be acknowledged
//   IONPReady  out  non-posted access finished, CPU may be acknowledged
//   IOBUSY     out  slow-bus transaction outstanding
//   IOERR      out  one-cycle pulse, watchdog expired
// ---------------------------------------------------------------------------
module iobus_sequencer #(
  parameter int unsigned POST_EN = 1,
  parameter int unsigned REQ_MIN = 2,
  parameter int unsigned WDT_MAX = 4095
) (
  input  logic FCLK,
  input  logic nRST,
  input  logic BACT,
  input  logic IOCS,
  input  logic IOPWCS,
  input  logic nWE,
  input  logic IOACT,
  input  logic IODONE,
  output logic IOREQ,
  output logic ALE,
  output logic IOPWReady,
  output logic IONPReady,
  output logic IOBUSY,
  output logic IOERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // reqcnt counts completed PEND cycles, so the request has been visible for
  // reqcnt+1 cycles when the exit condition is evaluated.
  localparam logic [3:0]  REQ_THRESH = 4'(REQ_MIN - 1);
  // The watchdog flags on the edge where it reaches WDT_MAX; the following
  // cycle (IOERR visible) is then completed like an IODONE.
  localparam logic [11:0] WDT_LAST   = 12'(WDT_MAX - 1);
  localparam logic        POST_ON    = (POST_EN != 0);

  state_e      state_q,   state_d;
  logic        taken_q,   taken_d;
  logic        posted_q,  posted_d;
  logic        ioreq_q,   ioreq_d;
  logic        ale_q,     ale_d;
  logic        pwready_q, pwready_d;
  logic        npready_q, npready_d;
  logic        busy_q,    busy_d;
  logic        ioerr_q,   ioerr_d;
  logic [3:0]  reqcnt_q,  reqcnt_d;
  logic [11:0] wdt_q,     wdt_d;

  logic access_p;
  logic accept;
  logic finish;

  assign access_p = IOCS && IOPWCS && !nWE && POST_ON;
  // Non-posted is simply any I/O access that is not posted, so IOCS alone
  // qualifies a new transaction.
  assign accept   = (state_q == IDLE) && BACT && !taken_q && IOCS;
  // IODONE, or the cycle in which the watchdog error is being shown.
  assign finish   = (state_q == ACTIVE) && (IODONE || ioerr_q);

  // NOTE: every variable gets a default before the case so that no path
  // leaves it unassigned; this keeps the block purely combinational.
  always_comb begin
    state_d   = state_q;
    taken_d   = taken_q && BACT;
    posted_d  = posted_q;
    ioreq_d   = ioreq_q;
    ale_d     = 1'b0;
    pwready_d = pwready_q && BACT;
    npready_d = npready_q && BACT;
    ioerr_d   = 1'b0;
    reqcnt_d  = reqcnt_q;
    wdt_d     = wdt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = PEND;
          ale_d    = 1'b1;
          ioreq_d  = 1'b1;
          taken_d  = 1'b1;
          posted_d = access_p;
          reqcnt_d = '0;
          if (access_p) pwready_d = 1'b1;
        end
      end
      PEND: begin
        if (IOACT && (reqcnt_q >= REQ_THRESH)) begin
          state_d = ACTIVE;
          ioreq_d = 1'b0;
          wdt_d   = '0;
        end else if (reqcnt_q != 4'hF) begin
          reqcnt_d = reqcnt_q + 4'd1;
        end
      end
      ACTIVE: begin
        if (finish) begin
          state_d = IDLE;
          // taken_q still set means the CPU cycle that started this
          // transaction is the one on the bus; if AS dropped meanwhile the
          // ready is suppressed and the slow cycle simply completes.
          if (!posted_q && BACT && taken_q) npready_d = 1'b1;
        end else begin
          wdt_d   = wdt_q + 12'd1;
          ioerr_d = (wdt_q == WDT_LAST);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: all registers are cleared by the asynchronous reset; there is no
  // storage array here that could be left unreset.
  always_ff @(posedge FCLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      taken_q   <= 1'b0;
      posted_q  <= 1'b0;
      ioreq_q   <= 1'b0;
      ale_q     <= 1'b0;
      pwready_q <= 1'b0;
      npready_q <= 1'b0;
      busy_q    <= 1'b0;
      ioerr_q   <= 1'b0;
      reqcnt_q  <= '0;
      wdt_q     <= '0;
    end else begin
      state_q   <= state_d;
      taken_q   <= taken_d;
      posted_q  <= posted_d;
      ioreq_q   <= ioreq_d;
      ale_q     <= ale_d;
      pwready_q <= pwready_d;
      npready_q <= npready_d;
      busy_q    <= busy_d;
      ioerr_q   <= ioerr_d;
      reqcnt_q  <= reqcnt_d;
      wdt_q     <= wdt_d;
    end
  end

  assign IOREQ     = ioreq_q;
  assign ALE       = ale_q;
  assign IOPWReady = pwready_q;
  assign IONPReady = npready_q;
  assign IOBUSY    = busy_q;
  assign IOERR     = ioerr_q;

endmodule

// File: tb/tb_iobus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_iobus_sequencer
//   Two sequencers share one stimulus stream: dut_a posts writes
//   (REQ_MIN=2, WDT_MAX=40), dut_b never posts (REQ_MIN=3, WDT_MAX=8).
//   A transaction-level model predicts every output each cycle; directed
//   literal expectations pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_iobus_sequencer;

  localparam int A_POST = 1, A_REQ = 2, A_WDT = 40;
  localparam int B_POST = 0, B_REQ = 3, B_WDT = 8;

  localparam int PH_IDLE = 0, PH_REQ = 1, PH_BUS = 2;

  logic FCLK, nRST, BACT, IOCS, IOPWCS, nWE, IOACT, IODONE;
  logic a_ioreq, a_ale, a_pwr, a_npr, a_busy, a_err;
  logic b_ioreq, b_ale, b_pwr, b_npr, b_busy, b_err;

  int n_checks = 0;
  int n_errors = 0;

  iobus_sequencer #(.POST_EN(A_POST), .REQ_MIN(A_REQ), .WDT_MAX(A_WDT)) dut_a (
    .FCLK(FCLK), .nRST(nRST), .BACT(BACT), .IOCS(IOCS), .IOPWCS(IOPWCS),
    .nWE(nWE), .IOACT(IOACT), .IODONE(IODONE),
    .IOREQ(a_ioreq), .ALE(a_ale), .IOPWReady(a_pwr), .IONPReady(a_npr),
    .IOBUSY(a_busy), .IOERR(a_err)
  );

  iobus_sequencer #(.POST_EN(B_POST), .REQ_MIN(B_REQ), .WDT_MAX(B_WDT)) dut_b (
    .FCLK(FCLK), .nRST(nRST), .BACT(BACT), .IOCS(IOCS), .IOPWCS(IOPWCS),
    .nWE(nWE), .IOACT(IOACT), .IODONE(IODONE),
    .IOREQ(b_ioreq), .ALE(b_ale), .IOPWReady(b_pwr), .IONPReady(b_npr),
    .IOBUSY(b_busy), .IOERR(b_err)
  );

  initial begin
    FCLK = 1'b0;
    forever #5 FCLK = ~FCLK;
  end

  // ---------------- model ----------------
  typedef struct packed {
    int phase;        // idle / requesting / slow cycle running
    int req_cycles;   // cycles IOREQ has been visible, including this one
    int act_cycles;   // cycles spent in the slow cycle, including this one
    bit taken;
    bit posted;
    bit ale;
    bit ioreq;
    bit pwr;
    bit npr;
    bit ioerr;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;

  // Given the state visible in the current cycle and the inputs sampled at
  // the coming edge, return what must be visible after that edge.
  function automatic mdl_t step(input mdl_t m, input bit b, input bit cs,
                                input bit pw, input bit wen, input bit act,
                                input bit done, input int post_en,
                                input int req_min, input int wdt_max);
    mdl_t n;
    bit   want_post;
    n = m;
    want_post = cs && pw && !wen && (post_en != 0);
    n.ale   = 1'b0;
    n.ioerr = 1'b0;
    if (!b) begin
      n.taken = 1'b0;
      n.pwr   = 1'b0;
      n.npr   = 1'b0;
    end
    case (m.phase)
      PH_IDLE: begin
        if (b && cs && !m.taken) begin
          n.phase      = PH_REQ;
          n.ale        = 1'b1;
          n.ioreq      = 1'b1;
          n.taken      = 1'b1;
          n.posted     = want_post;
          n.req_cycles = 1;
          if (want_post) n.pwr = 1'b1;
        end
      end
      PH_REQ: begin
        if (act && m.req_cycles >= req_min) begin
          n.phase      = PH_BUS;
          n.ioreq      = 1'b0;
          n.act_cycles = 1;
        end else begin
          n.req_cycles = m.req_cycles + 1;
        end
      end
      default: begin
        if (done || m.ioerr) begin
          n.phase = PH_IDLE;
          if (!m.posted && b && m.taken) n.npr = 1'b1;
        end else begin
          if (m.act_cycles == wdt_max) n.ioerr = 1'b1;
          n.act_cycles = m.act_cycles + 1;
        end
      end
    endcase
    return n;
  endfunction

  // Bit order: [5]=ALE [4]=IOREQ [3]=IOPWReady [2]=IONPReady [1]=IOBUSY [0]=IOERR
  function automatic logic [5:0] exp_vec(input mdl_t m);
    return {m.ale, m.ioreq, m.pwr, m.npr, (m.phase != PH_IDLE), m.ioerr};
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  string names [6] = '{"IOERR", "IOBUSY", "IONPReady", "IOPWReady", "IOREQ", "ALE"};
  logic [5:0] a_out, b_out, ea, eb;
  assign a_out = {a_ale, a_ioreq, a_pwr, a_npr, a_busy, a_err};
  assign b_out = {b_ale, b_ioreq, b_pwr, b_npr, b_busy, b_err};

  always @(posedge FCLK) begin
    #2;
    ea = exp_vec(ma);
    eb = exp_vec(mb);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("model a.%s", names[i]), 32'(a_out[i]), 32'(ea[i]));
      check($sformatf("model b.%s", names[i]), 32'(b_out[i]), 32'(eb[i]));
    end
  end

  // ---------------- driver ----------------
  // Called just after a falling edge: drive the inputs for this cycle,
  // advance the model, and return at the next falling edge.
  task automatic cyc(input bit b, input bit cs, input bit pw, input bit wen,
                     input bit act, input bit done);
    BACT = b; IOCS = cs; IOPWCS = pw; nWE = wen; IOACT = act; IODONE = done;
    if (nRST) begin
      ma = step(ma, b, cs, pw, wen, act, done, A_POST, A_REQ, A_WDT);
      mb = step(mb, b, cs, pw, wen, act, done, B_POST, B_REQ, B_WDT);
    end else begin
      ma = '0;
      mb = '0;
    end
    @(negedge FCLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    nRST = 1'b0; BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0;
    nWE = 1'b1; IOACT = 1'b0; IODONE = 1'b0;
    @(negedge FCLK);
    idle(2);
    nRST = 1'b1;
    idle(2);
    check("reset a.IOBUSY", a_busy, 0);
    check("reset b.outputs", b_out, 0);

    // ---- non-posted read: IOACT at +3, IODONE at +10 ----
    cyc(1, 1, 0, 1, 0, 0);                       // c0
    check("rd a.ALE +1", a_ale, 1);
    check("rd b.ALE +1", b_ale, 1);
    check("rd a.IOREQ +1", a_ioreq, 1);
    cyc(1, 1, 0, 1, 0, 0);                       // c1
    cyc(1, 1, 0, 1, 0, 0);                       // c2
    check("rd a.IOREQ +3", a_ioreq, 1);
    cyc(1, 1, 0, 1, 1, 0);                       // c3
    check("rd a.IOREQ +4", a_ioreq, 0);
    check("rd b.IOREQ +4", b_ioreq, 0);
    check("rd a.IOBUSY +4", a_busy, 1);
    for (int i = 4; i < 10; i++) cyc(1, 1, 0, 1, 1, 0);
    check("rd a.IONPReady +10", a_npr, 0);
    cyc(1, 1, 0, 1, 1, 1);                       // c10 IODONE
    check("rd a.IONPReady +11", a_npr, 1);
    check("rd b.IONPReady +11", b_npr, 1);
    check("rd a.IOBUSY +11", a_busy, 0);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    check("rd a.IONPReady hold", a_npr, 1);
    cyc(0, 0, 0, 1, 0, 0);                       // BACT low
    check("rd a.IONPReady release", a_npr, 0);
    idle(2);

    // ---- posted write, second write deferred behind the first ----
    cyc(1, 1, 1, 0, 0, 0);                       // c0
    check("pw a.ALE +1", a_ale, 1);
    check("pw a.IOPWReady +1", a_pwr, 1);
    check("pw a.IOBUSY +1", a_busy, 1);
    check("pw b.ALE +1", b_ale, 1);
    check("pw b.IOPWReady +1", b_pwr, 0);
    cyc(1, 1, 1, 0, 0, 0);                       // c1
    cyc(1, 1, 1, 0, 1, 0);                       // c2
    cyc(0, 0, 0, 1, 1, 0);                       // c3
    check("pw a.IOPWReady release", a_pwr, 0);
    cyc(0, 0, 0, 1, 1, 0);                       // c4
    cyc(0, 0, 0, 1, 1, 0);                       // c5
    cyc(1, 1, 1, 0, 1, 0);                       // c6 second write arrives
    check("pw a.deferred ALE", a_ale, 0);
    check("pw a.deferred IOPWReady", a_pwr, 0);
    for (int i = 7; i < 11; i++) cyc(1, 1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 0);                       // c11
    check("pw b.IOERR wdt", b_err, 1);
    cyc(1, 1, 1, 0, 1, 0);                       // c12
    check("pw b.no ready after wdt", b_npr, 0);
    check("pw b.IDLE after wdt", b_busy, 0);
    cyc(1, 1, 1, 0, 1, 0);                       // c13
    check("pw b.second ALE", b_ale, 1);
    for (int i = 14; i < 20; i++) cyc(1, 1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 1);                       // c20 IODONE
    check("pw a.IDLE gap", a_busy, 0);
    check("pw a.no ALE in gap", a_ale, 0);
    check("pw b.IONPReady no-post", b_npr, 1);
    cyc(1, 1, 1, 0, 1, 0);                       // c21
    check("pw a.second ALE", a_ale, 1);
    check("pw a.second IOPWReady", a_pwr, 1);
    cyc(1, 1, 1, 0, 1, 0);                       // c22
    cyc(1, 1, 1, 0, 1, 0);                       // c23
    cyc(0, 0, 0, 1, 1, 0);                       // c24
    cyc(0, 0, 0, 1, 1, 1);                       // c25 IODONE
    check("pw a.done no NPReady", a_npr, 0);
    check("pw a.IDLE", a_busy, 0);
    idle(2);

    // ---- IOACT held low: IOREQ must stay asserted ----
    cyc(1, 1, 0, 1, 0, 0);
    check("req a.IOREQ c1", a_ioreq, 1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 1, 0, 1, 0, 0);
      check($sformatf("req a.IOREQ c%0d", i + 1), a_ioreq, 1);
    end
    cyc(1, 1, 0, 1, 1, 0);                       // IOACT rises
    check("req a.IOREQ drop", a_ioreq, 0);
    check("req b.IOREQ drop", b_ioreq, 0);
    cyc(1, 1, 0, 1, 1, 0);
    cyc(1, 1, 0, 1, 1, 1);
    check("req a.IONPReady", a_npr, 1);
    cyc(0, 0, 0, 1, 0, 0);
    idle(2);

    // ---- non-posted cycle abandoned by the CPU before IODONE ----
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 1);
    check("abn a.IONPReady suppressed", a_npr, 0);
    check("abn a.IDLE", a_busy, 0);
    check("abn b.IDLE", b_busy, 0);
    idle(2);

    // ---- non-I/O access: nothing happens ----
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 1, 1);
    check("nio a.IOBUSY", a_busy, 0);
    check("nio b.ALE", b_ale, 0);
    idle(2);

    // ---- watchdog, no IODONE ever ----
    for (int i = 0; i <= 10; i++) cyc(1, 1, 0, 1, 1, 0);
    check("wdt b.IOERR early", b_err, 0);
    cyc(1, 1, 0, 1, 1, 0);                       // c11
    check("wdt b.IOERR", b_err, 1);
    check("wdt b.IOBUSY during err", b_busy, 1);
    cyc(1, 1, 0, 1, 1, 0);                       // c12
    check("wdt b.IOERR pulse", b_err, 0);
    check("wdt b.IONPReady", b_npr, 1);
    check("wdt b.IDLE", b_busy, 0);
    for (int i = 13; i < 42; i++) cyc(1, 1, 0, 1, 1, 0);
    check("wdt a.IOERR early", a_err, 0);
    cyc(1, 1, 0, 1, 1, 0);                       // c42
    check("wdt a.IOERR", a_err, 1);
    cyc(1, 1, 0, 1, 1, 0);                       // c43
    check("wdt a.IONPReady", a_npr, 1);
    check("wdt a.IDLE", a_busy, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(2);

    // ---- asynchronous reset in the middle of a slow cycle ----
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, 1, 0);
    check("rst a.busy before", a_busy, 1);
    #2 nRST = 1'b0;
    #1;
    check("rst a.outputs async", a_out, 0);
    check("rst b.outputs async", b_out, 0);
    ma = '0;
    mb = '0;
    @(negedge FCLK);
    cyc(1, 1, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    nRST = 1'b1;
    cyc(0, 0, 0, 1, 0, 0);
    check("rst a.IOBUSY after", a_busy, 0);
    check("rst b.IOBUSY after", b_busy, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
